// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Imported by the loader top and its word packer.
package imem_loader_pkg;

    // Instruction width used across the core.
    localparam int unsigned ILEN = 32;

    // Fill value for unused upper lanes of a short final word.
    localparam logic [7:0] PAD_BYTE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer with a registered word-valid pulse.
// The output word register is separate from the lane register.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic [7:0]      data_i,
    input  logic            last_i,
    output logic [ILEN-1:0] word_o,
    output logic            word_vld_o
);

    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     lanes_q, lanes_d;
    logic [ILEN-1:0] word_q, word_d;
    logic            vld_q, vld_d;
    logic            complete;
    logic [ILEN-1:0] assembled;

    assign complete = push_i & ((byte_cnt_q == 2'd3) | last_i);

    // Build the word being completed: stored lanes, current byte, pad above.
    always_comb begin
        assembled = {4{PAD_BYTE}};
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < byte_cnt_q) begin
                assembled[8*i +: 8] = lanes_q[8*i +: 8];
            end
        end
        assembled[{byte_cnt_q, 3'b000} +: 8] = data_i;
    end

    // Next-state for lane storage, byte counter and output word.
    always_comb begin
        lanes_d    = lanes_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        vld_d      = 1'b0;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
        end else if (push_i) begin
            if (complete) begin
                byte_cnt_d = 2'd0;
                word_d     = assembled;
                vld_d      = 1'b1;
            end else begin
                lanes_d[{byte_cnt_q, 3'b000} +: 8] = data_i;
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= 2'd0;
            lanes_q    <= '0;
            word_q     <= '0;
            vld_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            lanes_q    <= lanes_d;
            word_q     <= word_d;
            vld_q      <= vld_d;
        end
    end

    assign word_o     = word_q;
    assign word_vld_o = vld_q;

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, holding the core in
// reset until a complete program has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ILEN-1:0]   imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   pending;
    logic [ILEN-1:0]   word;
    logic              word_vld;
    logic              xfer;
    logic              full;
    logic              overflow;
    logic              push;
    logic              enter;

    assign s_ready  = (state_q == ST_LOAD);
    assign xfer     = s_valid & s_ready;
    // A word still in the write stage already occupies its slot.
    assign pending  = cnt_q + {{ADDR_W{1'b0}}, word_vld};
    assign full     = (pending == (ADDR_W+1)'(DEPTH));
    assign overflow = xfer & full;
    assign push     = xfer & ~full;
    assign enter    = start & (state_q != ST_LOAD);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (enter),
        .push_i     (push),
        .data_i     (s_data),
        .last_i     (s_last),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    // Load sequencing and word counter next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (overflow) begin
                    state_d = ST_ERR;
                end else if (push && s_last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter) begin
            cnt_d = '0;
        end else if (word_vld) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and word counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_we    = word_vld;
    assign imem_addr  = cnt_q[ADDR_W-1:0];
    assign imem_wdata = word;
    assign core_hold  = (state_q != ST_DONE);
    assign load_done  = (state_q == ST_DONE);
    assign load_err   = (state_q == ST_ERR);
    assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory.
// Checks writes, status levels, overflow, reload and mid-load reset.
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;

    int tests;
    int fails;
    int we_cnt;
    int base;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) we_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 8) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            tests++;
            fails++;
            $display("FAIL send_ready: observed s_ready=0 expected 1");
        end
        tick();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    logic [7:0]  p1 [8];
    logic [31:0] w;

    initial begin
        tests = 0; fails = 0; we_cnt = 0;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0;
        s_data = 8'h00; s_last = 1'b0;
        p1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        // Reset values
        #2 rst = 1'b0;
        #1;
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_hold", 32'(core_hold), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("idle_ready", 32'(s_ready), 32'd0);
        chk("idle_hold", 32'(core_hold), 32'd1);
        chk("idle_we_cnt", 32'(we_cnt), 32'd0);

        // Two full words, continuous valid
        pulse_start();
        chk("ld_ready", 32'(s_ready), 32'd1);
        base = we_cnt;
        for (int i = 0; i < 8; i++) begin
            send(p1[i], i == 7);
            if (i == 3) begin
                chk("w0_we", 32'(imem_we), 32'd1);
                chk("w0_addr", 32'(imem_addr), 32'd0);
                chk("w0_data", imem_wdata, 32'h0000_0013);
            end
            if (i == 4) begin
                chk("w0_pulse", 32'(imem_we), 32'd0);
                chk("w0_wc", 32'(word_count), 32'd1);
            end
        end
        chk("w1_we", 32'(imem_we), 32'd1);
        chk("w1_addr", 32'(imem_addr), 32'd1);
        chk("w1_data", imem_wdata, 32'h0010_0093);
        chk("p1_done", 32'(load_done), 32'd1);
        chk("p1_hold", 32'(core_hold), 32'd0);
        chk("p1_ready", 32'(s_ready), 32'd0);
        idle();
        tick();
        chk("p1_wc", 32'(word_count), 32'd2);
        chk("p1_we_off", 32'(imem_we), 32'd0);
        chk("p1_writes", 32'(we_cnt - base), 32'd2);

        // Partial final word
        pulse_start();
        chk("pt_wc0", 32'(word_count), 32'd0);
        base = we_cnt;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        chk("pt_we", 32'(imem_we), 32'd1);
        chk("pt_addr", 32'(imem_addr), 32'd0);
        chk("pt_data", imem_wdata, 32'h00CC_BBAA);
        chk("pt_done", 32'(load_done), 32'd1);
        idle();
        tick();
        chk("pt_wc", 32'(word_count), 32'd1);
        chk("pt_writes", 32'(we_cnt - base), 32'd1);

        // Reload from DONE with gaps; start inside LOAD is ignored
        pulse_start();
        chk("rl_done", 32'(load_done), 32'd0);
        chk("rl_wc0", 32'(word_count), 32'd0);
        base = we_cnt;
        send(8'h11, 1'b0); idle(); tick();
        send(8'h22, 1'b0); idle(); tick();
        start = 1'b1;
        send(8'h33, 1'b0);
        start = 1'b0;
        idle(); tick();
        pulse_start();
        chk("rl_ready", 32'(s_ready), 32'd1);
        send(8'h44, 1'b0);
        chk("rl_w0_we", 32'(imem_we), 32'd1);
        chk("rl_w0_addr", 32'(imem_addr), 32'd0);
        chk("rl_w0_data", imem_wdata, 32'h4433_2211);
        idle(); tick();
        send(8'h55, 1'b0); idle(); tick();
        send(8'h66, 1'b0); idle(); tick();
        send(8'h77, 1'b0); idle(); tick();
        send(8'h88, 1'b1);
        chk("rl_w1_addr", 32'(imem_addr), 32'd1);
        chk("rl_w1_data", imem_wdata, 32'h8877_6655);
        idle(); tick();
        chk("rl_wc", 32'(word_count), 32'd2);
        chk("rl_writes", 32'(we_cnt - base), 32'd2);

        // Overflow: DEPTH words then one extra byte
        pulse_start();
        base = we_cnt;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0);
            if (i % 4 == 3) begin
                w = {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)};
                chk("ov_we", 32'(imem_we), 32'd1);
                chk("ov_addr", 32'(imem_addr), 32'(i / 4));
                chk("ov_data", imem_wdata, w);
            end
        end
        send(8'h10, 1'b0);
        chk("ov_err", 32'(load_err), 32'd1);
        chk("ov_ready", 32'(s_ready), 32'd0);
        chk("ov_hold", 32'(core_hold), 32'd1);
        chk("ov_we_off", 32'(imem_we), 32'd0);
        chk("ov_wc", 32'(word_count), 32'd4);
        idle(); tick(); tick();
        chk("ov_writes", 32'(we_cnt - base), 32'd4);
        chk("ov_err_hold", 32'(load_err), 32'd1);

        // Reset in the middle of a word
        pulse_start();
        chk("mr_err_clr", 32'(load_err), 32'd0);
        base = we_cnt;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        idle();
        rst = 1'b0;
        #1;
        chk("mr_ready", 32'(s_ready), 32'd0);
        chk("mr_we", 32'(imem_we), 32'd0);
        chk("mr_hold", 32'(core_hold), 32'd1);
        chk("mr_wc", 32'(word_count), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("mr_writes", 32'(we_cnt - base), 32'd0);
        pulse_start();
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        send(8'hB3, 1'b0);
        send(8'hB4, 1'b0);
        chk("mr_w_we", 32'(imem_we), 32'd1);
        chk("mr_w_addr", 32'(imem_addr), 32'd0);
        chk("mr_w_data", imem_wdata, 32'hB4B3_B2B1);
        idle(); tick();
        chk("mr_wc1", 32'(word_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
